alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 6-bit combinational ALU.
- Adds WIDTH generalisation, a 4-bit opcode space with logic, shift and compare ops, and status flags.
- Adds valid/ready handshakes on input and output, plus an iterative multi-cycle multiply.
- Sits between the operand/control source and the result consumer in the datapath.

Parameters:
- WIDTH, 6, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- fxn  in  4  opcode.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept.
- X  out  WIDTH  registered result.
- flags  out  4  {C,V,N,Z}, registered with X.
- out_valid  out  1  X/flags valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  multiply in progress.

Behaviour:
- Reset: already decided — one clock clk; rst asynchronous, active-high.
- While rst is high: X=0, flags=0, out_valid=0, busy=0, state=IDLE, multiply counter=0. in_ready=0 while rst is high.
- Reset mid-multiply aborts the multiply; no result is produced.
- Opcodes (two's complement throughout):
  - 0000 A; 0001 B; 0010 -A; 0011 -B.
  - 0100 signed A<B (result 1 or 0, zero-extended).
  - 0101 ~(A^B); 0110 A+B; 0111 A-B; 1000 MUL (low WIDTH bits of A*B).
  - 1001 A&B; 1010 A|B; 1011 A^B.
  - 1100 A<<B[SHW-1:0]; 1101 logical A>>B[SHW-1:0]; 1110 arithmetic A>>>B[SHW-1:0].
  - 1111 unsigned A<B.
  - Any shift amount >= WIDTH gives 0, or sign-fill for 1110.
- Flags:
  - Z = (X==0).
  - N = X[WIDTH-1].
  - C = carry-out for 0110; NOT borrow for 0111 (C=1 when A>=B unsigned); for MUL, C=1 if any of the upper WIDTH product bits is nonzero; 0 for all other ops.
  - V = signed overflow for 0110/0111; V=1 for -A/-B of the most negative value (result equals the operand); 0 otherwise.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Transfer on in_valid && in_ready at a rising edge.
  - Output holds X/flags stable while out_valid && !out_ready.
  - out_valid clears on out_ready, unless a new result loads on the same edge.
- FSM:
  - IDLE: a non-MUL accept loads X/flags and sets out_valid at the accept edge (latency 1, full throughput with out_ready=1). A MUL accept latches A and B, clears the accumulator, sets cnt=0, and goes to MUL with busy=1.
  - MUL: one shift-add step per edge on B bit cnt. After WIDTH steps, load X/flags, set out_valid, go to IDLE, busy=0.
  - out_valid therefore rises WIDTH edges after the MUL accept edge.
  - in_ready=0 throughout MUL. The output slot is drained before MUL entry, so completion never collides with a held result.
- Back-to-back: with out_ready held 1, a new op can be accepted on the same edge that a result is consumed.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 1000 behaves as above.
- Undefined: MUL state and multiplier are not built. Opcode 1000 completes with latency 1 as X=0, flags={C=0,V=1,N=0,Z=1}, signalling an unsupported op. busy is tied to 0.

Decomposition:
- Package alu_pkg: opcode localparams/enum (OP_PASSA … OP_LTU), FSM state enum {IDLE,MUL}, flag bit index constants FLG_Z=0, FLG_N=1, FLG_V=2, FLG_C=3.
- One natural sub-module: alu_mul_iter (shift-add datapath: accumulator, counter, done pulse), instantiated only under ALU_MUL_EN.
- Single-cycle op evaluation stays in alu_seq as a combinational case.

Test Plan:
- Reset: assert rst mid-MUL (A=5, B=3) -> X=0, flags=0, out_valid=0, busy=0 immediately; after release, in_ready=1 and no stale result appears.
- WIDTH=6, add: A=31, B=1, fxn=0110 -> X=32 (100000), V=1, N=1, C=0, Z=0, out_valid on the edge after accept.
- Subtract and compare: A=3, B=5, fxn=0111 -> X=62, C=0, N=1. fxn=0100 with A=3, B=5 -> X=1. fxn=1111 with A=63, B=1 -> X=0, Z=1.
- MUL: A=7, B=9 -> X=63 (low 6 bits of 63), C=0, out_valid exactly 6 edges after accept. A=12, B=12 -> X=16 (144 mod 64), C=1. With ALU_MUL_EN undefined -> X=0, V=1, Z=1 at latency 1.
- Backpressure: out_ready=0, issue 0110 (A=2, B=2) then a second op -> X=4 held stable, in_ready=0. Raise out_ready -> second op accepted on the same edge the first result drains.
- Negate/shift: A=32, fxn=0010 -> X=32, V=1. A=40, B=2, fxn=1110 -> X=58. B=7 (>=6), fxn=1100 -> X=0, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSA = 4'b0000,
    OP_PASSB = 4'b0001,
    OP_NEGA  = 4'b0010,
    OP_NEGB  = 4'b0011,
    OP_LTS   = 4'b0100,
    OP_XNOR  = 4'b0101,
    OP_ADD   = 4'b0110,
    OP_SUB   = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_AND   = 4'b1001,
    OP_OR    = 4'b1010,
    OP_XOR   = 4'b1011,
    OP_SHL   = 4'b1100,
    OP_SHR   = 4'b1101,
    OP_SRA   = 4'b1110,
    OP_LTU   = 4'b1111
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock while run_i is high.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 run_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, addend;
  logic [CW-1:0]      cnt_q;

  always_comb begin
    addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_d  = acc_q + addend;
  end

  // The last step's sum is exposed directly so the product lands on the same edge.
  assign done_o = run_i && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (run_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and status flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 1000.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       fxn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] X,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        x_q, x_d;
  logic [3:0]              flags_q, flags_d;
  logic                    ovalid_q, ovalid_d;
  logic                    accept, load, loadC, loadV;
  logic [WIDTH-1:0]        loadX;

  logic [WIDTH:0]          sum, diff;
  logic [SHW-1:0]          shamt;
  logic                    shOver, ltS;
  logic signed [WIDTH-1:0] sraVal;
  logic [WIDTH-1:0]        resX;
  logic                    resC, resV;

  assign sum    = {1'b0, A} + {1'b0, B};
  assign diff   = {1'b0, A} - {1'b0, B};
  assign shamt  = B[SHW-1:0];
  assign shOver = 32'(shamt) >= WIDTH;
  assign ltS    = $signed(A) < $signed(B);
  assign sraVal = $signed(A) >>> shamt;

  always_comb begin
    resX = '0;
    resC = 1'b0;
    resV = 1'b0;
    case (op_e'(fxn))
      OP_PASSA: resX = A;
      OP_PASSB: resX = B;
      OP_NEGA:  begin resX = -A; resV = (A == MOST_NEG); end
      OP_NEGB:  begin resX = -B; resV = (B == MOST_NEG); end
      OP_LTS:   resX = {{(WIDTH-1){1'b0}}, ltS};
      OP_XNOR:  resX = ~(A ^ B);
      OP_ADD: begin
        resX = sum[WIDTH-1:0];
        resC = sum[WIDTH];
        resV = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        resX = diff[WIDTH-1:0];
        resC = ~diff[WIDTH];
        resV = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL:   resX = '0;
`else
      OP_MUL:   resV = 1'b1;
`endif
      OP_AND:   resX = A & B;
      OP_OR:    resX = A | B;
      OP_XOR:   resX = A ^ B;
      OP_SHL:   resX = shOver ? '0 : (A << shamt);
      OP_SHR:   resX = shOver ? '0 : (A >> shamt);
      OP_SRA:   resX = shOver ? {WIDTH{A[WIDTH-1]}} : sraVal;
      OP_LTU:   resX = {{(WIDTH-1){1'b0}}, (A < B)};
      default:  resX = '0;
    endcase
  end

  assign in_ready = !rst && (state_q == IDLE) && (!ovalid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  logic                 isMul, mulDone;
  logic [2*WIDTH-1:0]   mulProd;

  assign isMul = (op_e'(fxn) == OP_MUL);
  assign busy  = (state_q == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && isMul),
    .run_i   (state_q == MUL),
    .a_i     (A),
    .b_i     (B),
    .done_o  (mulDone),
    .prod_o  (mulProd)
  );
`else
  assign busy = 1'b0;
`endif

  // A fresh result wins over draining, so out_valid stays high on back-to-back edges.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    flags_d  = flags_q;
    ovalid_d = ovalid_q && !out_ready;
    loadX    = resX;
    loadC    = resC;
    loadV    = resV;
`ifdef ALU_MUL_EN
    load = accept && !isMul;
    if (accept && isMul) begin
      state_d = MUL;
    end
    if (mulDone) begin
      state_d = IDLE;
      load    = 1'b1;
      loadX   = mulProd[WIDTH-1:0];
      loadC   = |mulProd[2*WIDTH-1:WIDTH];
      loadV   = 1'b0;
    end
`else
    load = accept;
`endif
    if (load) begin
      x_d            = loadX;
      flags_d[FLG_C] = loadC;
      flags_d[FLG_V] = loadV;
      flags_d[FLG_N] = loadX[WIDTH-1];
      flags_d[FLG_Z] = (loadX == '0);
      ovalid_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      flags_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      flags_q  <= flags_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign X         = x_q;
  assign flags     = flags_q;
  assign out_valid = ovalid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against an integer model.
module tb_alu_seq;

  localparam int W    = 6;
  localparam int SHW  = $clog2(W);
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic [3:0]   fxn;
  logic         in_valid, in_ready;
  logic [W-1:0] X;
  logic [3:0]   flags;
  logic         out_valid, out_ready, busy;

  int checkCount = 0;
  int errCount   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .fxn       (fxn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Integer reference: returns {C,V,N,Z,X} computed from signed/unsigned arithmetic.
  function automatic logic [W+3:0] modelOp(input int op, input int a, input int b);
    int sa, sb, x, c, v, r, sh, lo, hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    sa = (a > hi) ? a - (1 << W) : a;
    sb = (b > hi) ? b - (1 << W) : b;
    sh = b % (1 << SHW);
    x = 0; c = 0; v = 0;
    case (op)
      0:  x = a;
      1:  x = b;
      2:  begin x = (-a) & MASK; v = (sa == lo) ? 1 : 0; end
      3:  begin x = (-b) & MASK; v = (sb == lo) ? 1 : 0; end
      4:  x = (sa < sb) ? 1 : 0;
      5:  x = ~(a ^ b) & MASK;
      6:  begin r = sa + sb; x = (a + b) & MASK; c = (a + b > MASK) ? 1 : 0; v = (r < lo || r > hi) ? 1 : 0; end
      7:  begin r = sa - sb; x = (a - b) & MASK; c = (a >= b) ? 1 : 0; v = (r < lo || r > hi) ? 1 : 0; end
`ifdef ALU_MUL_EN
      8:  begin r = a * b; x = r % (1 << W); c = (r / (1 << W) != 0) ? 1 : 0; end
`else
      8:  begin x = 0; v = 1; end
`endif
      9:  x = a & b;
      10: x = a | b;
      11: x = a ^ b;
      12: x = (sh >= W) ? 0 : (a * (1 << sh)) & MASK;
      13: x = (sh >= W) ? 0 : a / (1 << sh);
      14: x = (sh >= W) ? ((sa < 0) ? MASK : 0) : ((sa >>> sh) & MASK);
      15: x = (a < b) ? 1 : 0;
      default: x = 0;
    endcase
    return {c[0], v[0], (x >= (1 << (W - 1))), (x == 0), x[W-1:0]};
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    A = a; B = b; fxn = f; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic sawValid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; fxn = '0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({X, flags, out_valid, busy, in_ready} !== '0)
      $display("[TB] FAIL reset_state: got X=%0d flags=%b ov=%b busy=%b ir=%b, expected all 0", X, flags, out_valid, busy, in_ready);
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL reset_release_ready: got %b, expected 1", in_ready); end
    applyStimulus(5, 3, 4'b1000);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    checkCount++;
    if ({busy, out_valid, in_ready} !== 3'b100) begin
      errCount++;
      $display("[TB] FAIL mul_in_progress: got busy=%b ov=%b ir=%b, expected 1 0 0", busy, out_valid, in_ready);
    end
`endif
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if ({X, flags, out_valid, busy, in_ready} !== '0) begin
      errCount++;
      $display("[TB] FAIL reset_mid_mul: got X=%0d flags=%b ov=%b busy=%b ir=%b, expected all 0", X, flags, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkCount++;
    if (sawValid !== 1'b0 || in_ready !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL reset_no_stale: got sawValid=%b ir=%b, expected 0 1", sawValid, in_ready);
    end
  endtask

  task automatic test_add_sub();
    applyStimulus(31, 1, 4'b0110);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0110, 6'd32}) begin
      errCount++;
      $display("[TB] FAIL add_31_1: got ov=%b flags=%b X=%0d, expected ov=1 flags=0110 X=32", out_valid, flags, X);
    end
    applyStimulus(3, 5, 4'b0111);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0010, 6'd62}) begin
      errCount++;
      $display("[TB] FAIL sub_3_5: got ov=%b flags=%b X=%0d, expected ov=1 flags=0010 X=62", out_valid, flags, X);
    end
    applyStimulus(3, 5, 4'b0100);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0000, 6'd1}) begin
      errCount++;
      $display("[TB] FAIL lts_3_5: got ov=%b flags=%b X=%0d, expected ov=1 flags=0000 X=1", out_valid, flags, X);
    end
    applyStimulus(63, 1, 4'b1111);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0001, 6'd0}) begin
      errCount++;
      $display("[TB] FAIL ltu_63_1: got ov=%b flags=%b X=%0d, expected ov=1 flags=0001 X=0", out_valid, flags, X);
    end
  endtask

  task automatic test_mul();
    int edges;
    logic [W-1:0] ma [2] = '{6'd7, 6'd12};
    logic [W-1:0] mb [2] = '{6'd9, 6'd12};
`ifdef ALU_MUL_EN
    logic [W+3:0] mexp [2] = '{{4'b0010, 6'd63}, {4'b1000, 6'd16}};
    int           mlat     = W;
`else
    logic [W+3:0] mexp [2] = '{{4'b0101, 6'd0}, {4'b0101, 6'd0}};
    int           mlat     = 1;
`endif
    for (int i = 0; i < 2; i++) begin
      applyStimulus(ma[i], mb[i], 4'b1000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      while (out_valid !== 1'b1 && edges < 4 * W) begin
        @(posedge clk); #1;
        edges++;
      end
      checkCount++;
      if (edges != mlat || out_valid !== 1'b1 || {flags, X} !== mexp[i]) begin
        errCount++;
        $display("[TB] FAIL mul_%0d_%0d: got edges=%0d ov=%b flags=%b X=%0d, expected edges=%0d ov=1 flags=%b X=%0d",
                 ma[i], mb[i], edges, out_valid, flags, X, mlat, mexp[i][W+3:W], mexp[i][W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(2, 2, 4'b0110);
    @(negedge clk);
    checkCount++;
    if ({out_valid, in_ready, flags, X} !== {1'b1, 1'b0, 4'b0000, 6'd4}) begin
      errCount++;
      $display("[TB] FAIL bp_first: got ov=%b ir=%b flags=%b X=%0d, expected ov=1 ir=0 flags=0000 X=4", out_valid, in_ready, flags, X);
    end
    applyStimulus(3, 4, 4'b0110);
    repeat (2) @(negedge clk);
    checkCount++;
    if ({out_valid, in_ready, X} !== {1'b1, 1'b0, 6'd4}) begin
      errCount++;
      $display("[TB] FAIL bp_hold: got ov=%b ir=%b X=%0d, expected ov=1 ir=0 X=4", out_valid, in_ready, X);
    end
    out_ready = 1'b1;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL bp_ready_rise: got %b, expected 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, X} !== {1'b1, 6'd7}) begin
      errCount++;
      $display("[TB] FAIL bp_second: got ov=%b X=%0d, expected ov=1 X=7", out_valid, X);
    end
    @(negedge clk);
    checkCount++;
    if (out_valid !== 1'b0) begin errCount++; $display("[TB] FAIL bp_drain: got ov=%b, expected 0", out_valid); end
  endtask

  task automatic test_neg_shift();
    applyStimulus(32, 0, 4'b0010);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0110, 6'd32}) begin
      errCount++;
      $display("[TB] FAIL neg_32: got ov=%b flags=%b X=%0d, expected ov=1 flags=0110 X=32", out_valid, flags, X);
    end
    applyStimulus(40, 2, 4'b1110);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0010, 6'd58}) begin
      errCount++;
      $display("[TB] FAIL sra_40_2: got ov=%b flags=%b X=%0d, expected ov=1 flags=0010 X=58", out_valid, flags, X);
    end
    applyStimulus(21, 7, 4'b1100);
    @(negedge clk); in_valid = 1'b0;
    checkCount++;
    if ({out_valid, flags, X} !== {1'b1, 4'b0001, 6'd0}) begin
      errCount++;
      $display("[TB] FAIL shl_over: got ov=%b flags=%b X=%0d, expected ov=1 flags=0001 X=0", out_valid, flags, X);
    end
  endtask

  task automatic test_random();
    int a, b, f, waited;
    logic [W+3:0] expV;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 0;
        1:       a = MASK >> 1;
        2:       a = 1 << (W - 1);
        default: a = $urandom_range(0, MASK);
      endcase
      b = $urandom_range(0, MASK);
      f = $urandom_range(0, 15);
      expV = modelOp(f, a, b);
      applyStimulus(W'(a), W'(b), 4'(f));
      @(posedge clk); #1;
      in_valid = 1'b0;
      waited = 0;
      while (out_valid !== 1'b1 && waited < 4 * W) begin
        @(posedge clk); #1;
        waited++;
      end
      checkCount++;
      if (out_valid !== 1'b1 || {flags, X} !== expV) begin
        errCount++;
        $display("[TB] FAIL random_op%0d a=%0d b=%0d: got ov=%b flags=%b X=%0d, expected ov=1 flags=%b X=%0d",
                 f, a, b, out_valid, flags, X, expV[W+3:W], expV[W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, f;
    logic [W+3:0] expQ[$];
    logic [W+3:0] expV;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, MASK);
      b = $urandom_range(0, MASK);
      f = $urandom_range(0, 15);
`ifdef ALU_MUL_EN
      if (f == 8) f = 6;
`endif
      expQ.push_back(modelOp(f, a, b));
      applyStimulus(W'(a), W'(b), 4'(f));
      checkCount++;
      if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_ready_%0d: got %b, expected 1", i, in_ready); end
      @(negedge clk);
      expV = expQ.pop_front();
      checkCount++;
      if (out_valid !== 1'b1 || {flags, X} !== expV) begin
        errCount++;
        $display("[TB] FAIL b2b_result_%0d: got ov=%b flags=%b X=%0d, expected ov=1 flags=%b X=%0d",
                 i, out_valid, flags, X, expV[W+3:W], expV[W-1:0]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_neg_shift();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
